// File: rtl/vx_barrier_unit_pkg.sv
// vx_barrier_unit_pkg
//   Shared core types for the warp barrier path. Provides the width helper
//   used to derive warp/barrier index widths, the default core geometry and
//   the gpu_barrier_t record that the GPU unit emits for barrier commits.
//   No ports (package).
package vx_barrier_unit_pkg;

  localparam int NUM_WARPS_DEF    = 4;
  localparam int NUM_BARRIERS_DEF = 4;

  // Index width for n items; a single item still needs one bit of index.
  function automatic int bits_for(input int n);
    int r;
    if (n > 1) begin
      r = $clog2(n);
    end else begin
      r = 1;
    end
    return r;
  endfunction

  localparam int NW_BITS = bits_for(NUM_WARPS_DEF);
  localparam int NB_BITS = bits_for(NUM_BARRIERS_DEF);

  typedef struct packed {
    logic               valid;
    logic [NB_BITS-1:0] id;
    logic [NW_BITS-1:0] size_m1;
  } gpu_barrier_t;

endpackage

// File: rtl/vx_barrier_unit_if.sv
// vx_barrier_unit_if
//   Warp-control commit bus into the barrier unit and the stall/release
//   response back to the scheduler.
//   master: drives ctl_valid, ctl_wid, bar_valid, bar_id, bar_size_m1;
//           observes stall_wmask, release_valid, release_wmask, err.
//   slave : the barrier unit (opposite directions).
interface vx_barrier_unit_if #(
  parameter int NUM_WARPS    = 4,
  parameter int NUM_BARRIERS = 4
) ();
  import vx_barrier_unit_pkg::*;

  localparam int W_BITS = bits_for(NUM_WARPS);
  localparam int B_BITS = bits_for(NUM_BARRIERS);

  logic                 ctl_valid;
  logic [W_BITS-1:0]    ctl_wid;
  logic                 bar_valid;
  logic [B_BITS-1:0]    bar_id;
  logic [W_BITS-1:0]    bar_size_m1;
  logic [NUM_WARPS-1:0] stall_wmask;
  logic                 release_valid;
  logic [NUM_WARPS-1:0] release_wmask;
  logic                 err;

  modport master (
    output ctl_valid, ctl_wid, bar_valid, bar_id, bar_size_m1,
    input  stall_wmask, release_valid, release_wmask, err
  );

  modport slave (
    input  ctl_valid, ctl_wid, bar_valid, bar_id, bar_size_m1,
    output stall_wmask, release_valid, release_wmask, err
  );

endinterface

// File: rtl/vx_barrier_slot.sv
// vx_barrier_slot
//   State of one barrier slot: active flag, participant count minus one,
//   arrivals-so-far minus one and the mask of waiting warps.
//   Ports:
//     clk, reset       clock, asynchronous active-low reset
//     sel_i            an arrival targets this slot this cycle
//     drop_i           arrival warp already waits somewhere (rejected)
//     wid_i            arriving warp
//     size_m1_i        requested participants minus one
//     wmask_o          warps currently waiting on this slot
//     hit_release_o    this arrival completes the barrier
//     rel_wmask_o      warps freed when hit_release_o is set
//     dup_o            arriving warp already waits on this slot
//     size_mismatch_o  arrival disagrees with the slot's participant count
module vx_barrier_slot
  import vx_barrier_unit_pkg::*;
#(
  parameter int NUM_WARPS = 4,
  parameter int W_BITS    = bits_for(NUM_WARPS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sel_i,
  input  logic                 drop_i,
  input  logic [W_BITS-1:0]    wid_i,
  input  logic [W_BITS-1:0]    size_m1_i,
  output logic [NUM_WARPS-1:0] wmask_o,
  output logic                 hit_release_o,
  output logic [NUM_WARPS-1:0] rel_wmask_o,
  output logic                 dup_o,
  output logic                 size_mismatch_o
);

  localparam logic [W_BITS-1:0]    C_ONE  = W_BITS'(1);
  localparam logic [W_BITS-1:0]    C_ZERO = {W_BITS{1'b0}};
  localparam logic [NUM_WARPS-1:0] W_ONE  = NUM_WARPS'(1);
  localparam logic [NUM_WARPS-1:0] W_ZERO = {NUM_WARPS{1'b0}};

  logic                 active_q, active_d;
  logic [W_BITS-1:0]    size_q, size_d;
  logic [W_BITS-1:0]    count_q, count_d;
  logic [NUM_WARPS-1:0] wmask_q, wmask_d;

  logic [NUM_WARPS-1:0] wid_oh_s;
  logic                 dup_s;
  logic                 mism_s;
  logic                 accept_s;
  logic                 last_s;
  logic                 hit_s;

  // Classify the arrival and compute the slot's next state.
  always_comb begin
    wid_oh_s = W_ONE << wid_i;
    dup_s    = sel_i & active_q & (|(wmask_q & wid_oh_s));
    mism_s   = sel_i & active_q & (size_m1_i != size_q);
    accept_s = sel_i & ~drop_i & ~dup_s & ~mism_s;
    // An idle slot completes at once only for a single-participant barrier.
    if (active_q) begin
      last_s = ((count_q + C_ONE) == size_q);
    end else begin
      last_s = (size_m1_i == C_ZERO);
    end
    hit_s = accept_s & last_s;

    active_d = active_q;
    size_d   = size_q;
    count_d  = count_q;
    wmask_d  = wmask_q;
    if (accept_s) begin
      if (hit_s) begin
        active_d = 1'b0;
        size_d   = C_ZERO;
        count_d  = C_ZERO;
        wmask_d  = W_ZERO;
      end else if (active_q) begin
        count_d  = count_q + C_ONE;
        wmask_d  = wmask_q | wid_oh_s;
      end else begin
        active_d = 1'b1;
        size_d   = size_m1_i;
        count_d  = C_ZERO;
        wmask_d  = wid_oh_s;
      end
    end else begin
      active_d = active_q;
    end
  end

  // Slot state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active_q <= 1'b0;
      size_q   <= C_ZERO;
      count_q  <= C_ZERO;
      wmask_q  <= W_ZERO;
    end else begin
      active_q <= active_d;
      size_q   <= size_d;
      count_q  <= count_d;
      wmask_q  <= wmask_d;
    end
  end

  assign wmask_o         = wmask_q;
  assign hit_release_o   = hit_s;
  assign rel_wmask_o     = wmask_q | wid_oh_s;
  assign dup_o           = dup_s;
  assign size_mismatch_o = mism_s;

endmodule

// File: rtl/vx_barrier_unit.sv
// vx_barrier_unit
//   Per-core warp barrier tracker between the warp-control commit stage and
//   the warp scheduler. Arriving warps are held stalled until the last
//   participant of their barrier arrives; all are then released together.
//   Ports:
//     clk    core clock
//     reset  asynchronous active-low reset
//     bus    slave side of vx_barrier_unit_if (requests in, stall/release/err out)
module vx_barrier_unit
  import vx_barrier_unit_pkg::*;
#(
  parameter int NUM_WARPS    = 4,
  parameter int NUM_BARRIERS = 4
) (
  input logic              clk,
  input logic              reset,
  vx_barrier_unit_if.slave bus
);

  localparam int W_BITS = bits_for(NUM_WARPS);
  localparam int B_BITS = bits_for(NUM_BARRIERS);

  localparam logic [NUM_WARPS-1:0] W_ONE  = NUM_WARPS'(1);
  localparam logic [NUM_WARPS-1:0] W_ZERO = {NUM_WARPS{1'b0}};

  logic                 arrival_s;
  logic [NUM_WARPS-1:0] wid_oh_s;
  logic [NUM_WARPS-1:0] or_all_s;
  logic                 in_any_s;

  logic                 slot_sel_s   [NUM_BARRIERS];
  logic [NUM_WARPS-1:0] slot_wmask_s [NUM_BARRIERS];
  logic                 slot_hit_s   [NUM_BARRIERS];
  logic [NUM_WARPS-1:0] slot_rel_s   [NUM_BARRIERS];
  logic                 slot_dup_s   [NUM_BARRIERS];
  logic                 slot_mism_s  [NUM_BARRIERS];

  logic                 rel_hit_s;
  logic [NUM_WARPS-1:0] rel_mask_s;
  logic                 sel_any_s;
  logic                 slot_err_s;
  logic                 grow_s;

  logic [NUM_WARPS-1:0] stall_q, stall_d;
  logic                 rel_valid_q;
  logic [NUM_WARPS-1:0] rel_mask_q;
  logic                 err_q, err_d;

  assign arrival_s = bus.ctl_valid & bus.bar_valid;
  assign wid_oh_s  = W_ONE << bus.ctl_wid;

  // Union of every slot's waiters; a warp found here cannot arrive again.
  always_comb begin
    or_all_s = W_ZERO;
    for (int b = 0; b < NUM_BARRIERS; b++) begin
      or_all_s = or_all_s | slot_wmask_s[b];
    end
    in_any_s = arrival_s & (|(or_all_s & wid_oh_s));
  end

  genvar g;
  generate
    for (g = 0; g < NUM_BARRIERS; g++) begin : g_slot
      assign slot_sel_s[g] = arrival_s & (bus.bar_id == B_BITS'(g));

      vx_barrier_slot #(
        .NUM_WARPS (NUM_WARPS),
        .W_BITS    (W_BITS)
      ) u_slot (
        .clk             (clk),
        .reset           (reset),
        .sel_i           (slot_sel_s[g]),
        .drop_i          (in_any_s),
        .wid_i           (bus.ctl_wid),
        .size_m1_i       (bus.bar_size_m1),
        .wmask_o         (slot_wmask_s[g]),
        .hit_release_o   (slot_hit_s[g]),
        .rel_wmask_o     (slot_rel_s[g]),
        .dup_o           (slot_dup_s[g]),
        .size_mismatch_o (slot_mism_s[g])
      );
    end
  endgenerate

  // Gather release and error information from the addressed slot.
  always_comb begin
    rel_hit_s  = 1'b0;
    rel_mask_s = W_ZERO;
    sel_any_s  = 1'b0;
    slot_err_s = 1'b0;
    for (int b = 0; b < NUM_BARRIERS; b++) begin
      sel_any_s  = sel_any_s | slot_sel_s[b];
      slot_err_s = slot_err_s | slot_dup_s[b] | slot_mism_s[b];
      if (slot_hit_s[b]) begin
        rel_hit_s  = 1'b1;
        rel_mask_s = rel_mask_s | slot_rel_s[b];
      end else begin
        rel_mask_s = rel_mask_s;
      end
    end
  end

  // Next stall image: current waiters, plus a newly parked warp, minus the
  // warps freed by this cycle's release.
  always_comb begin
    err_d  = err_q | in_any_s | slot_err_s;
    grow_s = sel_any_s & ~in_any_s & ~slot_err_s & ~rel_hit_s;
    if (grow_s) begin
      stall_d = (or_all_s | wid_oh_s) & ~rel_mask_s;
    end else begin
      stall_d = or_all_s & ~rel_mask_s;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q     <= W_ZERO;
      rel_valid_q <= 1'b0;
      rel_mask_q  <= W_ZERO;
      err_q       <= 1'b0;
    end else begin
      stall_q     <= stall_d;
      rel_valid_q <= rel_hit_s;
      rel_mask_q  <= rel_mask_s;
      err_q       <= err_d;
    end
  end

  assign bus.stall_wmask   = stall_q;
  assign bus.release_valid = rel_valid_q;
  assign bus.release_wmask = rel_mask_q;
  assign bus.err           = err_q;

endmodule

// File: tb/tb_vx_barrier_unit.sv
module tb_vx_barrier_unit;

  localparam int NW = 4;
  localparam int NB = 4;

  logic clk = 1'b0;
  logic reset;

  vx_barrier_unit_if #(.NUM_WARPS(NW), .NUM_BARRIERS(NB)) bus ();

  vx_barrier_unit #(.NUM_WARPS(NW), .NUM_BARRIERS(NB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    int            cyc;
    bit            rv;
    logic [NW-1:0] rm;
    logic [NW-1:0] st;
    bit            er;
  } exp_t;

  exp_t sb[$];
  int   checks  = 0;
  int   errors  = 0;
  int   cyc_cnt = 0;

  // Reference model: per barrier, whether it is open, its participant
  // count minus one, and the set of warps already waiting on it.
  bit            m_open [NB];
  int            m_size [NB];
  logic [NW-1:0] m_set  [NB];
  bit            m_err;

  initial forever begin
    @(posedge clk);
    cyc_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  function automatic logic [NW-1:0] waiting();
    logic [NW-1:0] u;
    u = '0;
    for (int b = 0; b < NB; b++) u = u | m_set[b];
    return u;
  endfunction

  task automatic model_clear();
    for (int b = 0; b < NB; b++) begin
      m_open[b] = 1'b0;
      m_size[b] = 0;
      m_set[b]  = '0;
    end
    m_err = 1'b0;
  endtask

  // Apply one request at the next edge and queue the response the model predicts.
  task automatic drive(input bit cv, input bit bv, input int w, input int b, input int s);
    exp_t          e;
    logic [NW-1:0] wbit;
    @(posedge clk);
    #1;
    bus.ctl_valid   = cv;
    bus.bar_valid   = bv;
    bus.ctl_wid     = 2'(w);
    bus.bar_id      = 2'(b);
    bus.bar_size_m1 = 2'(s);
    e.rv = 1'b0;
    e.rm = '0;
    wbit = NW'(1) << w;
    if (cv && bv) begin
      if ((waiting() & wbit) != 0) begin
        m_err = 1'b1;
      end else if (!m_open[b]) begin
        if (s == 0) begin
          e.rv = 1'b1;
          e.rm = wbit;
        end else begin
          m_open[b] = 1'b1;
          m_size[b] = s;
          m_set[b]  = wbit;
        end
      end else if (s != m_size[b]) begin
        m_err = 1'b1;
      end else if ($countones(m_set[b]) + 1 == m_size[b] + 1) begin
        e.rv      = 1'b1;
        e.rm      = m_set[b] | wbit;
        m_open[b] = 1'b0;
        m_set[b]  = '0;
      end else begin
        m_set[b] = m_set[b] | wbit;
      end
    end
    e.st  = waiting();
    e.er  = m_err;
    e.cyc = cyc_cnt + 1;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 0, 0);
  endtask

  // Assert reset between edges, check outputs clear at once, then release it.
  task automatic do_reset();
    @(negedge clk);
    #1;
    bus.ctl_valid   = 1'b0;
    bus.bar_valid   = 1'b0;
    bus.ctl_wid     = '0;
    bus.bar_id      = '0;
    bus.bar_size_m1 = '0;
    reset = 1'b0;
    sb.delete();
    model_clear();
    #1;
    check("rst_stall_wmask", 32'(bus.stall_wmask), 32'd0);
    check("rst_release_valid", 32'(bus.release_valid), 32'd0);
    check("rst_release_wmask", 32'(bus.release_wmask), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    @(negedge clk);
    @(negedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Monitor: compare each cycle's registered outputs against the queued prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
        e = sb.pop_front();
        check("release_valid", 32'(bus.release_valid), 32'(e.rv));
        check("release_wmask", 32'(bus.release_wmask), 32'(e.rm));
        check("stall_wmask", 32'(bus.stall_wmask), 32'(e.st));
        check("err", 32'(bus.err), 32'(e.er));
      end
    end
  end

  initial begin
    int            rsize [NB];
    int            w, b, s;
    logic [NW-1:0] busy;
    reset           = 1'b0;
    bus.ctl_valid   = 1'b0;
    bus.bar_valid   = 1'b0;
    bus.ctl_wid     = '0;
    bus.bar_id      = '0;
    bus.bar_size_m1 = '0;
    model_clear();
    do_reset();

    // Reset while warps 0 and 1 wait on slot 2, then reuse slot 2.
    drive(1, 1, 0, 2, 2);
    drive(1, 1, 1, 2, 2);
    idle(1);
    do_reset();
    drive(1, 1, 3, 2, 1);
    drive(1, 1, 0, 2, 1);
    idle(1);

    // Four-warp barrier on slot 1.
    drive(1, 1, 2, 1, 3);
    drive(1, 1, 0, 1, 3);
    drive(1, 1, 3, 1, 3);
    drive(1, 1, 1, 1, 3);
    idle(1);

    // Single-participant barrier releases immediately; non-barrier request.
    drive(1, 1, 3, 0, 0);
    drive(1, 0, 2, 0, 1);
    idle(1);

    // Interleaved slots, then immediate reuse of slot 0.
    drive(1, 1, 0, 0, 1);
    drive(1, 1, 1, 1, 1);
    drive(1, 1, 2, 0, 1);
    drive(1, 1, 3, 1, 1);
    drive(1, 1, 2, 0, 1);
    drive(1, 1, 0, 0, 1);
    idle(1);

    // Duplicate and size-mismatch errors on slot 2, then completion.
    drive(1, 1, 1, 2, 2);
    drive(1, 1, 1, 2, 2);
    drive(1, 1, 0, 2, 1);
    drive(1, 1, 0, 2, 2);
    drive(1, 1, 3, 2, 2);
    idle(1);

    // Cross-slot membership error.
    do_reset();
    drive(1, 1, 0, 0, 1);
    drive(1, 1, 0, 3, 1);
    drive(1, 1, 1, 3, 1);
    drive(1, 1, 2, 3, 1);
    drive(1, 1, 1, 0, 1);
    idle(1);

    // Randomized rounds; sizes mostly consistent per slot, warps mostly free.
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int i = 0; i < NB; i++) rsize[i] = $urandom_range(0, 3);
      for (int i = 0; i < 250; i++) begin
        b    = $urandom_range(0, NB - 1);
        busy = waiting();
        w    = $urandom_range(0, NW - 1);
        if ($urandom_range(0, 9) != 0) begin
          for (int t = 0; t < 8 && busy[w]; t++) w = $urandom_range(0, NW - 1);
        end
        s = ($urandom_range(0, 19) != 0) ? rsize[b] : $urandom_range(0, 3);
        drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, w, b, s);
      end
      idle(2);
    end

    idle(2);
    @(negedge clk);
    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
